// File: rtl/game_stats_tracker.sv
// rtl/game_stats_tracker.sv - game phase sequencer with enemy, level, life and bonus-kill bookkeeping
module game_stats_tracker #(
    parameter int ENEMIES_PER_LEVEL = 20,
    parameter int START_LIVES       = 3,
    parameter int MAX_LIVES         = 6,
    parameter int MAX_LEVEL         = 9,
    parameter int EXTRA_LIFE_KILLS  = 10,
    parameter int CLEAR_FRAMES      = 120
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_tick_i,
    input  logic       start_i,
    input  logic       two_player_i,
    input  logic       enemy_killed_i,
    input  logic       killer_i,
    input  logic       player_1_hit_i,
    input  logic       player_2_hit_i,
    output logic [5:0] tank_left_o,
    output logic [3:0] level_o,
    output logic [3:0] player_1_live_left_o,
    output logic [3:0] player_2_live_left_o,
    output logic       playing_o,
    output logic       level_clear_o,
    output logic       game_over_o
);
    localparam int FW = $clog2(CLEAR_FRAMES + 1);
    localparam int KW = (EXTRA_LIFE_KILLS > 1) ? $clog2(EXTRA_LIFE_KILLS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CLEAR, S_OVER} state_t;

    state_t          state_q, state_d;
    logic [5:0]      tank_q, tank_d;
    logic [3:0]      level_q, level_d;
    logic [3:0]      p1_q, p1_d, p2_q, p2_d;
    logic [KW-1:0]   k1_q, k1_d, k2_q, k2_d;
    logic [KW-1:0]   k1_nx, k2_nx;
    logic [FW-1:0]   fc_q, fc_d;
    logic            kill_ok, bonus1, bonus2;

    // Returns {bonus, next_count}; the counter wraps to 0 on the bonus kill.
    function automatic logic [KW:0] kill_upd(input logic [KW-1:0] kc, input logic inc);
        logic [KW-1:0] n;
        logic          b;
        n = kc;
        b = 1'b0;
        if (inc && EXTRA_LIFE_KILLS != 0) begin
            if (kc == KW'(EXTRA_LIFE_KILLS - 1)) begin
                n = '0;
                b = 1'b1;
            end else begin
                n = kc + KW'(1);
            end
        end
        return {b, n};
    endfunction

    // Bonus and hit are summed before clamping so a same-cycle bonus+hit nets zero even at the ceiling.
    function automatic logic [3:0] lives_upd(input logic [3:0] l, input logic bonus, input logic hit);
        logic [4:0] t;
        t = {1'b0, l};
        if (l != 4'd0) t = t + {4'd0, bonus} - {4'd0, hit};
        if (t > 5'(MAX_LIVES)) t = 5'(MAX_LIVES);
        return t[3:0];
    endfunction

    always_comb begin
        state_d = state_q;
        tank_d  = tank_q;
        level_d = level_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        fc_d    = fc_q;
        kill_ok = enemy_killed_i && (tank_q != 6'd0);
        {bonus1, k1_nx} = kill_upd(k1_q, kill_ok && !killer_i);
        {bonus2, k2_nx} = kill_upd(k2_q, kill_ok && killer_i);
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    state_d = S_PLAY;
                    tank_d  = 6'(ENEMIES_PER_LEVEL);
                    level_d = 4'd1;
                    p1_d    = 4'(START_LIVES);
                    p2_d    = two_player_i ? 4'(START_LIVES) : 4'd0;
                    k1_d    = '0;
                    k2_d    = '0;
                end
            end
            S_PLAY: begin
                tank_d = kill_ok ? tank_q - 6'd1 : tank_q;
                k1_d   = k1_nx;
                k2_d   = k2_nx;
                p1_d   = lives_upd(p1_q, bonus1, player_1_hit_i);
                p2_d   = lives_upd(p2_q, bonus2, player_2_hit_i);
                if (p1_d == 4'd0 && p2_d == 4'd0) begin
                    state_d = S_OVER;
                end else if (tank_d == 6'd0) begin
                    state_d = S_CLEAR;
                    fc_d    = '0;
                end
            end
            S_CLEAR: begin
                if (frame_tick_i) begin
                    if (fc_q == FW'(CLEAR_FRAMES - 1)) begin
                        state_d = S_PLAY;
                        fc_d    = '0;
                        tank_d  = 6'(ENEMIES_PER_LEVEL);
                        level_d = (level_q == 4'(MAX_LEVEL)) ? 4'd1 : level_q + 4'd1;
                    end else begin
                        fc_d = fc_q + FW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            tank_q        <= '0;
            level_q       <= 4'd1;
            p1_q          <= '0;
            p2_q          <= '0;
            k1_q          <= '0;
            k2_q          <= '0;
            fc_q          <= '0;
            playing_o     <= 1'b0;
            level_clear_o <= 1'b0;
            game_over_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tank_q        <= tank_d;
            level_q       <= level_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            k1_q          <= k1_d;
            k2_q          <= k2_d;
            fc_q          <= fc_d;
            playing_o     <= (state_d == S_PLAY);
            level_clear_o <= (state_d == S_CLEAR);
            game_over_o   <= (state_d == S_OVER);
        end
    end

    assign tank_left_o          = tank_q;
    assign level_o              = level_q;
    assign player_1_live_left_o = p1_q;
    assign player_2_live_left_o = p2_q;
endmodule

// File: tb/tb_game_stats_tracker.sv
// tb/tb_game_stats_tracker.sv - scoreboard bench for game_stats_tracker
module tb_game_stats_tracker;
    localparam int IDLE = 0, PLAY = 1, CLEAR = 2, OVER = 3;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start, two_player, enemy_killed, killer, p1_hit, p2_hit;
    logic [5:0] tank_left;
    logic [3:0] level, p1_lives, p2_lives;
    logic       playing, level_clear, game_over;

    typedef struct packed {
        logic [5:0] tank;
        logic [3:0] level;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       play;
        logic       clear;
        logic       over;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    int m_state, m_tank, m_level, m_p1, m_p2, m_k1, m_k2, m_fc;

    game_stats_tracker dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .frame_tick_i        (frame_tick),
        .start_i             (start),
        .two_player_i        (two_player),
        .enemy_killed_i      (enemy_killed),
        .killer_i            (killer),
        .player_1_hit_i      (p1_hit),
        .player_2_hit_i      (p2_hit),
        .tank_left_o         (tank_left),
        .level_o             (level),
        .player_1_live_left_o(p1_lives),
        .player_2_live_left_o(p2_lives),
        .playing_o           (playing),
        .level_clear_o       (level_clear),
        .game_over_o         (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    endtask

    task automatic model_start(input logic tp);
        m_state = PLAY; m_tank = 20; m_level = 1; m_p1 = 3;
        m_p2 = tp ? 3 : 0; m_k1 = 0; m_k2 = 0;
    endtask

    task automatic model(input logic r, st, tp, k, kr, h1, h2, tk);
        bit b1, b2;
        b1 = 0; b2 = 0;
        if (r) begin
            m_state = IDLE; m_tank = 0; m_level = 1; m_p1 = 0; m_p2 = 0;
            m_k1 = 0; m_k2 = 0; m_fc = 0;
        end else if (m_state == IDLE || m_state == OVER) begin
            if (st) model_start(tp);
        end else if (m_state == PLAY) begin
            if (k && m_tank > 0) begin
                m_tank--;
                if (!kr) begin m_k1++; if (m_k1 == 10) begin m_k1 = 0; b1 = 1; end end
                else     begin m_k2++; if (m_k2 == 10) begin m_k2 = 0; b2 = 1; end end
            end
            if (m_p1 > 0) m_p1 = m_p1 + int'(b1) - int'(h1);
            if (m_p2 > 0) m_p2 = m_p2 + int'(b2) - int'(h2);
            if (m_p1 > 6) m_p1 = 6;
            if (m_p2 > 6) m_p2 = 6;
            if (m_p1 == 0 && m_p2 == 0) m_state = OVER;
            else if (m_tank == 0) begin m_state = CLEAR; m_fc = 0; end
        end else if (m_state == CLEAR && tk) begin
            m_fc++;
            if (m_fc == 120) begin
                m_fc = 0; m_tank = 20; m_state = PLAY;
                m_level = (m_level == 9) ? 1 : m_level + 1;
            end
        end
    endtask

    task automatic step(input logic r, st, tp, k, kr, h1, h2, tk);
        snap_t e, got;
        rst = r; start = st; two_player = tp; enemy_killed = k; killer = kr;
        p1_hit = h1; p2_hit = h2; frame_tick = tk;
        model(r, st, tp, k, kr, h1, h2, tk);
        e = '{tank: 6'(m_tank), level: 4'(m_level), p1: 4'(m_p1), p2: 4'(m_p2),
              play: (m_state == PLAY), clear: (m_state == CLEAR), over: (m_state == OVER)};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = '{tank_left, level, p1_lives, p2_lives, playing, level_clear, game_over};
        e = exp_q.pop_front();
        check("tank_left", int'(got.tank), int'(e.tank));
        check("level", int'(got.level), int'(e.level));
        check("p1_lives", int'(got.p1), int'(e.p1));
        check("p2_lives", int'(got.p2), int'(e.p2));
        check("playing", int'(got.play), int'(e.play));
        check("level_clear", int'(got.clear), int'(e.clear));
        check("game_over", int'(got.over), int'(e.over));
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic finish_clear();
        for (int i = 0; i < 130 && m_state == CLEAR; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic kills(input int n, input logic kr);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, kr, 0, 0, 0);
            if (m_state == CLEAR) finish_clear();
        end
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_level", int'(level), 1);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        check("idle_kill_tank", int'(tank_left), 0);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("start_tank", int'(tank_left), 20);
        check("start_p1", int'(p1_lives), 3);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        check("clear_flag", int'(level_clear), 1);
        step(0, 0, 0, 1, 0, 0, 0, 1);
        finish_clear();
        check("level_two", int'(level), 2);

        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        check("over_single", int'(game_over), 1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        kills(10, 1);
        check("p2_bonus", int'(p2_lives), 4);
        kills(20, 1);
        check("p2_sat", int'(p2_lives), 6);
        kills(10, 1);
        check("p2_sat_hold", int'(p2_lives), 6);
        finish_clear();

        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        check("over_both", int'(game_over), 1);
        step(0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        for (int lv = 0; lv < 8; lv++) kills(20, lv[0]);
        check("level_nine", int'(level), 9);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        finish_clear();
        check("level_wrap", int'(level), 1);

        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        check("rst_clear_flag", int'(level_clear), 0);
        idle_step();

        step(0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++)
            step(0, $urandom_range(99, 0) < 2, $urandom_range(1, 0) == 1,
                 $urandom_range(99, 0) < 35, $urandom_range(1, 0) == 1,
                 $urandom_range(99, 0) < 4, $urandom_range(99, 0) < 4,
                 $urandom_range(99, 0) < 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
